mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 33 +++
 rtl/mem_access_unit.sv | 165 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// CPU request/response and data-memory signals of mem_access_unit, bundled as one interface.
// slave is the unit's view; master is the CPU/memory side.
interface mem_access_unit_if;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_byte;
    logic              req_bsel;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_datain;
    logic [DATA_W-1:0] d_dataout;

    modport slave (
        input  req_valid, req_we, req_byte, req_bsel, req_addr, req_wdata,
        input  rsp_ready, d_dataout,
        output req_ready, rsp_valid, rsp_data, d_we, d_addr, d_datain
    );

    modport master (
        output req_valid, req_we, req_byte, req_bsel, req_addr, req_wdata,
        output rsp_ready, d_dataout,
        input  req_ready, rsp_valid, rsp_data, d_we, d_addr, d_datain
    );
endinterface

// File: rtl/mem_access_unit.sv
// Single-outstanding CPU load/store unit in front of a synchronous-read data memory.
// Optional byte access with read-modify-write merge: define MEM_ACCESS_UNIT_BYTE_EN.
module mem_access_unit (
    input  logic             clock,
    input  logic             reset_n,
    mem_access_unit_if.slave bus
);
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RSP  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;

    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_d_we;
    logic [ADDR_W-1:0] r_d_addr;
    logic [DATA_W-1:0] r_d_datain;
    logic              w_req_ready_nxt;
    logic              w_rsp_valid_nxt;
    logic [DATA_W-1:0] w_rsp_data_nxt;
    logic              w_d_we_nxt;
    logic [ADDR_W-1:0] w_d_addr_nxt;
    logic [DATA_W-1:0] w_d_datain_nxt;

`ifdef MEM_ACCESS_UNIT_BYTE_EN
    logic              r_byte;
    logic              r_bsel;
    logic              w_byte_nxt;
    logic              w_bsel_nxt;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_lane_load;

    // Store byte goes into the selected lane; the other lane keeps what memory returned.
    assign w_merged    = r_bsel ? {r_wdata[BYTE_W-1:0], bus.d_dataout[BYTE_W-1:0]}
                                : {bus.d_dataout[DATA_W-1:BYTE_W], r_wdata[BYTE_W-1:0]};
    assign w_lane_load = r_bsel ? {BYTE_W'(0), bus.d_dataout[DATA_W-1:BYTE_W]}
                                : {BYTE_W'(0), bus.d_dataout[BYTE_W-1:0]};
`else
    logic w_unused_byte;
    assign w_unused_byte = &{1'b0, bus.req_byte, bus.req_bsel};
`endif

    // Next state, request latches and next values of every registered output.
    always_comb begin
        w_state_nxt = r_state;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rsp_data_nxt = r_rsp_data;
`ifdef MEM_ACCESS_UNIT_BYTE_EN
        w_byte_nxt  = r_byte;
        w_bsel_nxt  = r_bsel;
`endif
        case (r_state)
            IDLE: begin
                w_rsp_data_nxt = '0;
                if (bus.req_valid && r_req_ready) begin
                    w_we_nxt    = bus.req_we;
                    w_addr_nxt  = bus.req_addr;
                    w_wdata_nxt = bus.req_wdata;
`ifdef MEM_ACCESS_UNIT_BYTE_EN
                    w_byte_nxt  = bus.req_byte;
                    w_bsel_nxt  = bus.req_bsel;
                    w_state_nxt = (bus.req_we && !bus.req_byte) ? WR : RD;
`else
                    w_state_nxt = bus.req_we ? WR : RD;
`endif
                end
            end
            RD: w_state_nxt = CAP;
            CAP: begin
`ifdef MEM_ACCESS_UNIT_BYTE_EN
                if (r_we) begin
                    w_wdata_nxt = w_merged;
                    w_state_nxt = WR;
                end else begin
                    w_rsp_data_nxt = r_byte ? w_lane_load : bus.d_dataout;
                    w_state_nxt    = RSP;
                end
`else
                w_rsp_data_nxt = bus.d_dataout;
                w_state_nxt    = RSP;
`endif
            end
            WR: begin
                w_rsp_data_nxt = '0;
                w_state_nxt    = RSP;
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    w_rsp_data_nxt = '0;
                    w_state_nxt    = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_req_ready_nxt = (w_state_nxt == IDLE);
        w_rsp_valid_nxt = (w_state_nxt == RSP);
        w_d_we_nxt      = (w_state_nxt == WR);
        w_d_addr_nxt    = ((w_state_nxt == RD) || (w_state_nxt == CAP) || (w_state_nxt == WR))
                          ? w_addr_nxt : '0;
        w_d_datain_nxt  = (w_state_nxt == WR) ? w_wdata_nxt : '0;
    end

    // State, request latches and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_d_we      <= 1'b0;
            r_d_addr    <= '0;
            r_d_datain  <= '0;
`ifdef MEM_ACCESS_UNIT_BYTE_EN
            r_byte      <= 1'b0;
            r_bsel      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_we        <= w_we_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_d_we      <= w_d_we_nxt;
            r_d_addr    <= w_d_addr_nxt;
            r_d_datain  <= w_d_datain_nxt;
`ifdef MEM_ACCESS_UNIT_BYTE_EN
            r_byte      <= w_byte_nxt;
            r_bsel      <= w_bsel_nxt;
`endif
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.d_we      = r_d_we;
    assign bus.d_addr    = r_d_addr;
    assign bus.d_datain  = r_d_datain;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: synchronous-read memory, array reference model, directed and random accesses.
module tb_mem_access_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic mem_clr = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   wr_count  = 0;
    int   acc_count = 0;

    always #5 clk = ~clk;

    mem_access_unit_if bus();

    mem_access_unit dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus.slave)
    );

    // Data memory: write when d_we, otherwise read data appears the cycle after d_addr is sampled.
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            bus.d_dataout <= 16'h0000;
        end else if (bus.d_we) begin
            mem[bus.d_addr] <= bus.d_datain;
        end else begin
            bus.d_dataout <= mem[bus.d_addr];
        end
    end

    always @(posedge clk) begin
        if (rst_n && bus.d_we) wr_count <= wr_count + 1;
        if (rst_n && bus.req_valid && bus.req_ready) acc_count <= acc_count + 1;
    end

    logic [15:0] ref_mem [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: what each access must return, how long it takes and how many writes it makes.
    task automatic model_access(input logic we, input logic byt, input logic bsel,
                                input logic [7:0] addr, input logic [15:0] wdata,
                                output logic [15:0] exp_rsp, output int exp_lat, output int exp_wr);
        logic        eff_byte;
        logic [15:0] word;
`ifdef MEM_ACCESS_UNIT_BYTE_EN
        eff_byte = byt;
`else
        eff_byte = 1'b0;
        if (byt) eff_byte = 1'b0;
`endif
        word = ref_mem[addr];
        if (we) begin
            exp_rsp = 16'h0000;
            exp_wr  = 1;
            if (eff_byte) begin
                if (bsel) word[15:8] = wdata[7:0];
                else      word[7:0]  = wdata[7:0];
                ref_mem[addr] = word;
                exp_lat = 4;
            end else begin
                ref_mem[addr] = wdata;
                exp_lat = 2;
            end
        end else begin
            exp_wr  = 0;
            exp_lat = 3;
            if (eff_byte) exp_rsp = bsel ? {8'h00, word[15:8]} : {8'h00, word[7:0]};
            else          exp_rsp = word;
        end
    endtask

    task automatic do_access(input string tag, input logic we, input logic byt, input logic bsel,
                             input logic [7:0] addr, input logic [15:0] wdata,
                             input int rsp_delay, input logic drop_valid);
        logic [15:0] exp_rsp;
        int exp_lat, exp_wr, lat, n, wr0, acc0;
        logic ok;
        model_access(we, byt, bsel, addr, wdata, exp_rsp, exp_lat, exp_wr);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_byte  = byt;
        bus.req_bsel  = bsel;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.rsp_ready = 1'b0;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check({tag, "_accept_timeout"}, 32'(0), 32'(1));
            bus.req_valid = 1'b0;
            return;
        end
        wr0  = wr_count;
        acc0 = acc_count;
        @(posedge clk); #1;
        if (drop_valid) bus.req_valid = 1'b0;
        lat = 1;
        ok  = 1'b1;
        while (!bus.rsp_valid && lat < 20) begin
            if (bus.req_ready) ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(exp_rsp));
        for (int i = 0; i < rsp_delay; i++) begin
            @(posedge clk); #1;
            if (!bus.rsp_valid || bus.rsp_data !== exp_rsp || bus.req_ready) ok = 1'b0;
        end
        check({tag, "_busy_hold"}, 32'(ok), 32'(1));
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check({tag, "_to_idle"}, 32'({bus.rsp_valid, bus.req_ready}), 32'(2'b01));
        check({tag, "_writes"}, 32'(wr_count - wr0), 32'(exp_wr));
        check({tag, "_accepts"}, 32'(acc_count - acc0), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_byte_word;
        int wr0;
        logic ok;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_byte  = 1'b0;
        bus.req_bsel  = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 16'h0000;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              32'({bus.req_ready, bus.rsp_valid, bus.d_we, bus.rsp_data}), 32'(0));
        check("reset_dbus", 32'({bus.d_addr, bus.d_datain}), 32'(0));
        @(negedge clk);
        mem_clr = 1'b0;
        rst_n   = 1'b1;
        #1;
        check("ready_before_edge", 32'(bus.req_ready), 32'(0));
        @(posedge clk); #1;
        check("ready_after_edge", 32'(bus.req_ready), 32'(1));

        // Store then load word
        do_access("st_beef", 1'b1, 1'b0, 1'b0, 8'h10, 16'hBEEF, 0, 1'b1);
        check("mem_10", 32'(mem[8'h10]), 32'(16'hBEEF));
        do_access("ld_beef", 1'b0, 1'b0, 1'b0, 8'h10, 16'h0000, 0, 1'b1);
        do_access("ld_stall", 1'b0, 1'b0, 1'b0, 8'h10, 16'h0000, 5, 1'b1);

        // Byte store/load on 0x20
        do_access("st_1234", 1'b1, 1'b0, 1'b0, 8'h20, 16'h1234, 0, 1'b1);
        do_access("st_byte", 1'b1, 1'b1, 1'b1, 8'h20, 16'h00AB, 1, 1'b1);
`ifdef MEM_ACCESS_UNIT_BYTE_EN
        exp_byte_word = 16'hAB34;
`else
        exp_byte_word = 16'h00AB;
`endif
        check("mem_20_after_byte_store", 32'(mem[8'h20]), 32'(exp_byte_word));
        do_access("ld_byte", 1'b0, 1'b1, 1'b0, 8'h20, 16'h0000, 0, 1'b1);

        // Reset pulse while a load is in RD
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_byte  = 1'b0;
        bus.req_addr  = 8'h33;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("rd_dbus", 32'({bus.d_we, bus.d_addr}), 32'({1'b0, 8'h33}));
        wr0 = wr_count;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              32'({bus.req_ready, bus.rsp_valid, bus.d_we, bus.d_addr, bus.rsp_data}), 32'(0));
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset_pulse", 32'(bus.req_ready), 32'(1));
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (bus.rsp_valid || bus.d_we) ok = 1'b0;
            @(posedge clk); #1;
        end
        check("no_rsp_after_reset", 32'(ok), 32'(1));
        check("no_write_after_reset", 32'(wr_count - wr0), 32'(0));

        // Back-to-back loads at address extremes, req_valid held high
        do_access("st_ff", 1'b1, 1'b0, 1'b0, 8'hFF, 16'hA5A5, 0, 1'b1);
        do_access("st_00", 1'b1, 1'b0, 1'b0, 8'h00, 16'h5A5A, 0, 1'b1);
        do_access("b2b_ff_a", 1'b0, 1'b0, 1'b0, 8'hFF, 16'h0000, 0, 1'b0);
        do_access("b2b_00_a", 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 0, 1'b0);
        do_access("b2b_ff_b", 1'b0, 1'b0, 1'b0, 8'hFF, 16'h0000, 1, 1'b0);
        do_access("b2b_00_b", 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 0, 1'b1);

        // Random mix against the reference model
        for (int i = 0; i < 40; i++) begin
            do_access($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 8'(8'h40 + $urandom_range(0, 7)),
                      16'($urandom), int'($urandom_range(0, 3)), 1'b1);
        end
        for (int a = 8'h40; a < 8'h48; a++) begin
            check($sformatf("final_mem_%0h", a), 32'(mem[a]), 32'(ref_mem[a]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
